switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 4, meaning number of input buffers/requesters.
REQ-002 SHALL have parameter NUM_OUTPORTS, default 4, meaning number of switch output ports.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port allocate  input  NUM_BUFFERS  per-input route-valid request from route compute.
REQ-006 SHALL have port out_sel  input  NUM_BUFFERS x clog2(NUM_OUTPORTS)  requested output port per input.
REQ-007 SHALL have port flit_valid  input  NUM_BUFFERS  head of input buffer holds a flit.
REQ-008 SHALL have port flit_tail  input  NUM_BUFFERS  flit at buffer head is last of its packet.
REQ-009 SHALL have port out_ready  input  NUM_OUTPORTS  downstream of output port can accept a flit (credit available).
REQ-010 SHALL have port in_pop  output  NUM_BUFFERS  flit at input head transfers this cycle; buffer dequeues.
REQ-011 SHALL have port xbar_sel  output  NUM_OUTPORTS x clog2(NUM_BUFFERS)  crossbar input select per output.
REQ-012 SHALL have port xbar_valid  output  NUM_OUTPORTS  output carries a valid flit this cycle.

Function
REQ-013 Each output port SHALL hold state IDLE or LOCKED plus registered owner index and round-robin pointer.
REQ-014 Input i SHALL request port p when allocate[i] && flit_valid[i] && out_sel[i]==p && input i owns no port.
REQ-015 IDLE port with >=1 request SHALL pick winner by round-robin starting at its pointer, go LOCKED with owner=winner at next edge.
REQ-016 On lock, pointer SHALL become (winner+1) mod NUM_BUFFERS; wrap-around from NUM_BUFFERS-1 to 0.
REQ-017 Arbitration latency SHALL be 1 cycle: request in cycle N, first possible transfer in cycle N+1.
REQ-018 LOCKED port p SHALL transfer when flit_valid[owner] && out_ready[p]; then in_pop[owner]=1, xbar_valid[p]=1, same cycle (combinational from registered state).
REQ-019 xbar_sel[p] SHALL equal owner whenever LOCKED, 0 when IDLE.
REQ-020 Transfer with flit_tail[owner]=1 SHALL return port to IDLE at next edge; new lock for that port earliest one cycle later.
REQ-021 LOCKED with out_ready[p]=0 or flit_valid[owner]=0 SHALL stall: no pop, xbar_valid[p]=0, lock held indefinitely.
REQ-022 An input SHALL own at most one port; owning input excluded from all arbitration until its lock releases.
REQ-023 Ports SHALL arbitrate independently; simultaneous locks on different ports by different inputs SHALL be allowed same cycle.
REQ-024 allocate deasserting while LOCKED SHALL NOT release the lock; only tail transfer or reset releases.
REQ-025 out_sel value >= NUM_OUTPORTS SHALL be ignored (no request).
REQ-026 Single-flit packet (head is tail) SHALL lock, transfer one cycle, release.

Reset
REQ-027 n_rst low SHALL asynchronously force all ports IDLE, owners 0, pointers 0.
REQ-028 During/after reset in_pop, xbar_valid, xbar_sel SHALL be 0 until a lock is established.
REQ-029 Reset mid-packet SHALL drop the lock with no further pops; upstream buffers are reset concurrently.

Structure
REQ-030 NUM_OUTPORTS default and enum sa_state_e {SA_IDLE, SA_LOCKED} SHALL live in chiplet_types_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, valid out), instantiated once per output port.

Verification (NUM_BUFFERS=4, NUM_OUTPORTS=4)
REQ-032 Input 2 requests port 1, 3-flit packet, out_ready=1 -> lock at cycle 1, in_pop[2] cycles 1-3, xbar_sel[1]=2, IDLE after cycle 3.
REQ-033 Inputs 0,1,3 request port 0 simultaneously, single-flit packets -> service order 0,1,3, each lock 2 cycles apart, pointer ends at 0 (wrap).
REQ-034 Input 1 locked on port 2, out_ready[2]=0 for 4 cycles -> no in_pop[1], xbar_valid[2]=0, lock held; resumes when ready returns.
REQ-035 Inputs 0->port 3 and 2->port 1 same cycle -> both locked next cycle, parallel transfers.
REQ-036 Assert n_rst low mid-packet on port 0 -> all outputs 0 immediately, state IDLE; new request after release locks normally with pointer 0.
REQ-037 Input 0 requests port 5 -> no lock, no pop on any port.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// ---------------------------------------------------------------------------
// chiplet_types_pkg
//   Shared types and defaults for the chiplet router blocks.
//   - NUM_OUTPORTS_DEF : default number of switch output ports
//   - sa_state_e       : per-output-port switch allocator state
// ---------------------------------------------------------------------------
package chiplet_types_pkg;

   localparam int NUM_OUTPORTS_DEF = 4;

   typedef enum logic {
      SA_IDLE   = 1'b0,
      SA_LOCKED = 1'b1
   } sa_state_e;

   // Width of the per-input output-port select. One code point beyond the
   // last port is always representable, so a bad route (e.g. port 5 of 4)
   // arrives as an out-of-range value and is dropped instead of aliasing
   // onto a real port.
   function automatic int sel_width(input int num_outports);
      return $clog2(num_outports + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr_i and wraps
//   around; the first set request wins.
//   Ports:
//     req_i   [N]   request vector
//     ptr_i   [PW]  highest-priority index for this round
//     gnt_o   [N]   one-hot grant
//     valid_o       at least one request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   int idx;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
//   Packet-granular switch allocator. Each output port is either IDLE or
//   LOCKED to one input buffer (its owner) until that input's tail flit
//   crosses. IDLE ports arbitrate round-robin among requesting inputs; the
//   lock takes effect at the next edge, so transfers start one cycle after
//   the request. Transfers are combinational from the registered lock.
//   Ports:
//     clk, n_rst              clock (rising), async active-low reset
//     allocate   [NB]         route computed for the head packet
//     out_sel    [NB][SEL_W]  requested output port per input
//     flit_valid [NB]         input buffer head holds a flit
//     flit_tail  [NB]         head flit is last of its packet
//     out_ready  [NP]         downstream credit available per output
//     in_pop     [NB]         input head transfers this cycle
//     xbar_sel   [NP][IDX_W]  crossbar input select per output (0 if IDLE)
//     xbar_valid [NP]         output carries a flit this cycle
// ---------------------------------------------------------------------------
module switch_allocator
   import chiplet_types_pkg::*;
#(
   parameter  int NUM_BUFFERS  = 4,
   parameter  int NUM_OUTPORTS = NUM_OUTPORTS_DEF,
   localparam int SEL_W        = sel_width(NUM_OUTPORTS),
   localparam int IDX_W        = $clog2(NUM_BUFFERS)
) (
   input  logic                                     clk,
   input  logic                                     n_rst,
   input  logic [NUM_BUFFERS-1:0]                   allocate,
   input  logic [NUM_BUFFERS-1:0][SEL_W-1:0]        out_sel,
   input  logic [NUM_BUFFERS-1:0]                   flit_valid,
   input  logic [NUM_BUFFERS-1:0]                   flit_tail,
   input  logic [NUM_OUTPORTS-1:0]                  out_ready,
   output logic [NUM_BUFFERS-1:0]                   in_pop,
   output logic [NUM_OUTPORTS-1:0][IDX_W-1:0]       xbar_sel,
   output logic [NUM_OUTPORTS-1:0]                  xbar_valid
);

   // Per-port views of the registered lock, gathered for cross-port logic.
   logic [NUM_OUTPORTS-1:0]                  locked;
   logic [NUM_OUTPORTS-1:0][IDX_W-1:0]       owner;
   logic [NUM_OUTPORTS-1:0]                  xfer;
   logic [NUM_BUFFERS-1:0]                   owned;
   logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] req;

   // An input holding any lock stays out of every arbitration, which keeps
   // each input bound to at most one port.
   always_comb begin
      owned = '0;
      for (int p = 0; p < NUM_OUTPORTS; p++)
         for (int i = 0; i < NUM_BUFFERS; i++)
            if (locked[p] && owner[p] == IDX_W'(i))
               owned[i] = 1'b1;
   end

   always_comb begin
      in_pop = '0;
      for (int p = 0; p < NUM_OUTPORTS; p++)
         for (int i = 0; i < NUM_BUFFERS; i++)
            if (xfer[p] && owner[p] == IDX_W'(i))
               in_pop[i] = 1'b1;
   end

   for (genvar p = 0; p < NUM_OUTPORTS; p++) begin : g_port
      sa_state_e               state_q, state_d;
      logic [IDX_W-1:0]        owner_q, owner_d;
      logic [IDX_W-1:0]        ptr_q, ptr_d;
      logic [NUM_BUFFERS-1:0]  gnt;
      logic                    gnt_vld;
      logic [IDX_W-1:0]        win;

      // Out-of-range selects never equal a real port index, so they drop out.
      for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_req
         assign req[p][i] = allocate[i] && flit_valid[i] && !owned[i] &&
                            (out_sel[i] == SEL_W'(p));
      end

      rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
         .req_i   (req[p]),
         .ptr_i   (ptr_q),
         .gnt_o   (gnt),
         .valid_o (gnt_vld)
      );

      always_comb begin
         win = '0;
         for (int i = 0; i < NUM_BUFFERS; i++)
            if (gnt[i]) win = IDX_W'(i);
      end

      assign locked[p]     = (state_q == SA_LOCKED);
      assign owner[p]      = owner_q;
      assign xfer[p]       = locked[p] && flit_valid[owner_q] && out_ready[p];
      assign xbar_valid[p] = xfer[p];
      assign xbar_sel[p]   = locked[p] ? owner_q : '0;

      always_comb begin
         state_d = state_q;
         owner_d = owner_q;
         ptr_d   = ptr_q;
         case (state_q)
            SA_IDLE: begin
               if (gnt_vld) begin
                  state_d = SA_LOCKED;
                  owner_d = win;
                  ptr_d   = (win == IDX_W'(NUM_BUFFERS - 1)) ? '0 : win + 1'b1;
               end
            end
            SA_LOCKED: begin
               // Only the tail crossing releases; allocate is not looked at.
               if (xfer[p] && flit_tail[owner_q]) begin
                  state_d = SA_IDLE;
                  owner_d = '0;
               end
            end
            default: state_d = SA_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            state_q <= SA_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
         end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
//   Table-driven bench for switch_allocator (4 inputs, 4 outputs). Each
//   table row is one cycle of stimulus with the outputs expected in that
//   same cycle; expectations go through a scoreboard queue and are checked
//   mid-cycle. Reset behaviour is covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

   localparam int NB    = 4;
   localparam int NP    = 4;
   localparam int SEL_W = 3;
   localparam int IDX_W = 2;

   logic                         clk   = 1'b0;
   logic                         n_rst = 1'b1;
   logic [NB-1:0]                allocate;
   logic [NB-1:0][SEL_W-1:0]     out_sel;
   logic [NB-1:0]                flit_valid;
   logic [NB-1:0]                flit_tail;
   logic [NP-1:0]                out_ready;
   logic [NB-1:0]                in_pop;
   logic [NP-1:0][IDX_W-1:0]     xbar_sel;
   logic [NP-1:0]                xbar_valid;

   always #5 clk = ~clk;

   switch_allocator #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NP)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .allocate   (allocate),
      .out_sel    (out_sel),
      .flit_valid (flit_valid),
      .flit_tail  (flit_tail),
      .out_ready  (out_ready),
      .in_pop     (in_pop),
      .xbar_sel   (xbar_sel),
      .xbar_valid (xbar_valid)
   );

   typedef struct {
      string      name;
      logic [3:0] al;
      logic [11:0] os;
      logic [3:0] fv, ft, rdy;
      logic [3:0] pop, xv;
      logic [7:0] xs;
   } vec_t;

   typedef struct {
      string      name;
      logic [3:0] pop, xv;
      logic [7:0] xs;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Pack four per-input port selects (input 3 first).
   function automatic logic [11:0] sel(input int s3, input int s2, input int s1, input int s0);
      logic [2:0] a, b, c, d;
      a = s3[2:0]; b = s2[2:0]; c = s1[2:0]; d = s0[2:0];
      return {a, b, c, d};
   endfunction

   task automatic add(input string n, input logic [3:0] al, input logic [11:0] os,
                      input logic [3:0] fv, input logic [3:0] ft, input logic [3:0] rdy,
                      input logic [3:0] pop, input logic [3:0] xv, input logic [7:0] xs);
      vec_t v;
      v.name = n; v.al = al; v.os = os; v.fv = fv; v.ft = ft; v.rdy = rdy;
      v.pop = pop; v.xv = xv; v.xs = xs;
      tbl.push_back(v);
   endtask

   task automatic expect_out(input string n, input logic [3:0] pop, input logic [3:0] xv,
                             input logic [7:0] xs);
      exp_t e;
      e.name = n; e.pop = pop; e.xv = xv; e.xs = xs;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (in_pop !== e.pop || xbar_valid !== e.xv || xbar_sel !== e.xs) begin
         errors++;
         $display("FAIL %s: got pop=%b xv=%b xs=%h, want pop=%b xv=%b xs=%h",
                  e.name, in_pop, xbar_valid, xbar_sel, e.pop, e.xv, e.xs);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      allocate   = v.al;
      out_sel    = v.os;
      flit_valid = v.fv;
      flit_tail  = v.ft;
      out_ready  = v.rdy;
      expect_out(v.name, v.pop, v.xv, v.xs);
      #2;
      check_out();
   endtask

   task automatic idle_inputs();
      allocate = '0; out_sel = '0; flit_valid = '0; flit_tail = '0; out_ready = '1;
   endtask

   initial begin
      vec_t v;

      // 3-flit packet, input 2 -> port 1
      add("A req",   4'b0100, sel(0,1,0,0), 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("A flit0", 4'b0100, sel(0,1,0,0), 4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b0010, 8'h08);
      add("A flit1", 4'b0100, sel(0,1,0,0), 4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b0010, 8'h08);
      add("A tail",  4'b0100, sel(0,1,0,0), 4'b0100, 4'b0100, 4'b1111, 4'b0100, 4'b0010, 8'h08);
      add("A idle",  4'b0000, sel(0,0,0,0), 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      // inputs 0,1,3 -> port 0, single-flit packets, then pointer wrap probe
      add("B req",   4'b1011, sel(0,0,0,0), 4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("B xfer0", 4'b1011, sel(0,0,0,0), 4'b1011, 4'b1011, 4'b1111, 4'b0001, 4'b0001, 8'h00);
      add("B arb1",  4'b1010, sel(0,0,0,0), 4'b1010, 4'b1010, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("B xfer1", 4'b1010, sel(0,0,0,0), 4'b1010, 4'b1010, 4'b1111, 4'b0010, 4'b0001, 8'h01);
      add("B arb3",  4'b1000, sel(0,0,0,0), 4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("B xfer3", 4'b1000, sel(0,0,0,0), 4'b1000, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 8'h03);
      add("B wrap",  4'b1001, sel(0,0,0,0), 4'b1001, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("B wrap0", 4'b1001, sel(0,0,0,0), 4'b1001, 4'b1001, 4'b1111, 4'b0001, 4'b0001, 8'h00);
      add("B arb3b", 4'b1000, sel(0,0,0,0), 4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("B xfr3b", 4'b1000, sel(0,0,0,0), 4'b1000, 4'b1000, 4'b1111, 4'b1000, 4'b0001, 8'h03);
      add("B idle",  4'b0000, sel(0,0,0,0), 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      // input 1 -> port 2, backpressure, allocate drop, reselect while owning
      add("C req",   4'b0010, sel(0,0,2,0), 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 8'h00);
      add("C stl1",  4'b0000, sel(0,0,2,0), 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 8'h10);
      add("C stl2",  4'b0000, sel(0,0,2,0), 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 8'h10);
      add("C stl3",  4'b0010, sel(0,0,0,0), 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 8'h10);
      add("C stl4",  4'b0010, sel(0,0,0,0), 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 8'h10);
      add("C nofv",  4'b0000, sel(0,0,0,0), 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h10);
      add("C flit",  4'b0000, sel(0,0,0,0), 4'b0010, 4'b0000, 4'b1111, 4'b0010, 4'b0100, 8'h10);
      add("C tail",  4'b0000, sel(0,0,0,0), 4'b0010, 4'b0010, 4'b1111, 4'b0010, 4'b0100, 8'h10);
      add("C idle",  4'b0000, sel(0,0,0,0), 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      // parallel locks: input 0 -> port 3, input 2 -> port 1
      add("D req",   4'b0101, sel(0,1,0,3), 4'b0101, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("D flit",  4'b0101, sel(0,1,0,3), 4'b0101, 4'b0000, 4'b1111, 4'b0101, 4'b1010, 8'h08);
      add("D tail",  4'b0101, sel(0,1,0,3), 4'b0101, 4'b0101, 4'b1111, 4'b0101, 4'b1010, 8'h08);
      add("D idle",  4'b0000, sel(0,0,0,0), 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      // out-of-range select
      add("E req5",  4'b0001, sel(0,0,0,5), 4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("E hold1", 4'b0001, sel(0,0,0,5), 4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 8'h00);
      add("E hold2", 4'b0001, sel(0,0,0,5), 4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 8'h00);

      // Reset with busy-looking inputs: outputs must stay quiet.
      allocate = '1; out_sel = '0; flit_valid = '1; flit_tail = '0; out_ready = '1;
      #1 n_rst = 1'b0;
      #2;
      expect_out("reset", 4'b0000, 4'b0000, 8'h00);
      check_out();
      repeat (2) @(negedge clk);
      expect_out("reset hold", 4'b0000, 4'b0000, 8'h00);
      check_out();
      idle_inputs();
      @(negedge clk);
      n_rst = 1'b1;

      foreach (tbl[i]) drive(tbl[i]);

      // Reset in the middle of a 3-flit packet on port 0.
      v.name = "F req"; v.al = 4'b0001; v.os = '0; v.fv = 4'b0001; v.ft = '0;
      v.rdy = 4'b1111; v.pop = '0; v.xv = '0; v.xs = '0;
      drive(v);
      v.name = "F flit0"; v.pop = 4'b0001; v.xv = 4'b0001;
      drive(v);
      #1 n_rst = 1'b0;
      #1;
      expect_out("F async rst", 4'b0000, 4'b0000, 8'h00);
      check_out();
      v.name = "F in rst"; v.pop = '0; v.xv = '0;
      drive(v);
      idle_inputs();
      @(negedge clk);
      n_rst = 1'b1;

      // After reset the pointer is back at 0: input 0 beats input 1.
      v.name = "G req"; v.al = 4'b0011; v.fv = 4'b0011; v.ft = 4'b0011;
      v.pop = '0; v.xv = '0; v.xs = '0;
      drive(v);
      v.name = "G xfer0"; v.pop = 4'b0001; v.xv = 4'b0001;
      drive(v);
      v.name = "G arb1"; v.al = 4'b0010; v.fv = 4'b0010; v.ft = 4'b0010;
      v.pop = '0; v.xv = '0;
      drive(v);
      v.name = "G xfer1"; v.pop = 4'b0010; v.xv = 4'b0001; v.xs = 8'h01;
      drive(v);
      v.name = "G idle"; v.al = '0; v.fv = '0; v.ft = '0;
      v.pop = '0; v.xv = '0; v.xs = '0;
      drive(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
